flash_sample_sched: RTL and testbench

Sequences playback from the on-board flash into the audio codec for the chipmunks design. Issues single-word Avalon-MM reads to the flash controller, splits each 32-bit word into two signed 16-bit samples (low half first), and feeds them through the codec write handshake. Sample emission is repeated, normal or decimated according to a playback mode. Sits between the `flash` instance and the audio core, and is driven by top-level switches and keys.

---
 rtl/flash_sched_pkg.sv | 24 ++
 rtl/codec_write_hs.sv | 47 ++++
 rtl/flash_sample_sched.sv | 144 ++++++++++++++
 tb/tb_flash_sample_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_sched_pkg.sv
// Shared types and constants for the flash sample playback scheduler.
package flash_sched_pkg;

    localparam int ADDR_W = 23;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_SLOW   = 2'b01;
    localparam logic [1:0] MODE_FAST   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        WAIT_RDY,
        WRITE,
        NEXT
    } state_t;

    typedef enum logic {
        HS_IDLE,
        HS_WRITE
    } hs_state_t;

endpackage

// File: rtl/codec_write_hs.sv
// Codec write handshake: raises write_s once the codec has room and holds it
// until the codec deasserts write_ready; done flags that final cycle.
module codec_write_hs
    import flash_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic write_ready,
    output logic write_s,
    output logic busy,
    output logic done
);

    hs_state_t state;

    // Strobe sequencer: idle until asked and ready, then strobe until ready drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HS_IDLE;
            write_s <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (start && write_ready) begin
                        state   <= HS_WRITE;
                        write_s <= 1'b1;
                    end
                end
                HS_WRITE: begin
                    if (!write_ready) begin
                        state   <= HS_IDLE;
                        write_s <= 1'b0;
                    end
                end
                default: begin
                    state   <= HS_IDLE;
                    write_s <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == HS_WRITE);
    assign done = busy && !write_ready;

endmodule

// File: rtl/flash_sample_sched.sv
// Flash-to-codec playback scheduler: reads one 32-bit word at a time from the
// flash Avalon-MM port and emits its two signed 16-bit halves (low first) to
// the codec, repeated (slow), normal, or low half only (fast).
// Optional feature macro: SAMPLE_ATTEN_EN (arithmetic right shift of samples).
module flash_sample_sched
    import flash_sched_pkg::*;
#(
    parameter int NUM_WORDS   = 2097152,
    parameter int ATTEN_SHIFT = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              run,
    input  logic [1:0]        mode,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_burstcount,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    input  logic              write_ready,
    output logic              write_s,
    output logic [15:0]       sample,
    output logic              done
);

`ifdef SAMPLE_ATTEN_EN
    localparam bit ATTEN_ON = 1'b1;
`else
    localparam bit ATTEN_ON = 1'b0;
`endif

    localparam int               SHIFT_AMT = ATTEN_ON ? ATTEN_SHIFT : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t      state;
    logic [15:0] hi_half;
    logic [1:0]  mode_q;
    logic        half;
    logic        rep;
    logic        hs_start;
    logic        hs_busy;
    logic        hs_done;

    // Sign-preserving attenuation; a zero shift leaves the sample untouched.
    function automatic logic [15:0] shape(input logic [15:0] h);
        logic signed [15:0] s;
        s = $signed(h) >>> SHIFT_AMT;
        return $unsigned(s);
    endfunction

    assign flash_mem_burstcount = 1'b1;
    assign hs_start             = (state == WAIT_RDY) && !hs_busy;

    codec_write_hs u_hs (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .start       (hs_start),
        .write_ready (write_ready),
        .write_s     (write_s),
        .busy        (hs_busy),
        .done        (hs_done)
    );

    // Main playback sequencer: fetch a word, emit its samples, advance address.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= IDLE;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
            sample            <= '0;
            done              <= 1'b0;
            hi_half           <= '0;
            mode_q            <= MODE_NORMAL;
            half              <= 1'b0;
            rep               <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state          <= REQ;
                        flash_mem_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        state          <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        hi_half <= flash_mem_readdata[31:16];
                        sample  <= shape(flash_mem_readdata[15:0]);
                        mode_q  <= mode;
                        half    <= 1'b0;
                        rep     <= 1'b0;
                        state   <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (write_ready) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (hs_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (mode_q == MODE_SLOW && !rep) begin
                        rep   <= 1'b1;
                        state <= WAIT_RDY;
                    end else if (!half && mode_q != MODE_FAST) begin
                        half   <= 1'b1;
                        rep    <= 1'b0;
                        sample <= shape(hi_half);
                        state  <= WAIT_RDY;
                    end else begin
                        if (flash_mem_address == LAST_ADDR) begin
                            flash_mem_address <= '0;
                            done              <= 1'b1;
                        end else begin
                            flash_mem_address <= flash_mem_address + 23'd1;
                        end
                        if (run) begin
                            flash_mem_read <= 1'b1;
                            state          <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    flash_mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_sched.sv
// Self-checking bench for flash_sample_sched (NUM_WORDS=4 to exercise wrap).
// Honours SAMPLE_ATTEN_EN in its expected-sample model.
module tb_flash_sample_sched;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        run;
    logic [1:0]  mode;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_burstcount;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic        write_ready;
    logic        write_s;
    logic [15:0] sample;
    logic        done;

    typedef struct {
        logic [15:0] smp;
        logic [22:0] addr;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] word;
        int          n;
        logic [15:0] s[4];
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          inject_req = 0;
    int          inject_seen = 0;
    logic        data_sel = 1'b0;
    logic [31:0] const_word = 32'h0;
    logic        acc;
    logic [22:0] acc_addr;
    logic        prev_ws = 1'b0;
    logic        prev_done = 1'b0;

    flash_sample_sched #(.NUM_WORDS(4), .ATTEN_SHIFT(6)) dut (
        .clk_clk                 (clk_clk),
        .reset_reset_n           (reset_reset_n),
        .run                     (run),
        .mode                    (mode),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .write_ready             (write_ready),
        .write_s                 (write_s),
        .sample                  (sample),
        .done                    (done)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic logic [15:0] shape(input logic [15:0] h);
`ifdef SAMPLE_ATTEN_EN
        logic signed [15:0] s;
        s = $signed(h) >>> 6;
        return $unsigned(s);
`else
        return h;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        else
            pass_cnt++;
    endtask

    // Flash and codec model: one-cycle read latency, codec ready 4 of every 8 cycles.
    always @(posedge clk_clk) begin
        acc      = flash_mem_read && !flash_mem_waitrequest && reset_reset_n;
        acc_addr = flash_mem_address;
        #1;
        cyc++;
        write_ready             = (cyc % 8) < 4;
        flash_mem_readdatavalid = acc;
        flash_mem_readdata      = data_sel ? const_word : 32'(acc_addr) * 32'd10002;
        if (inject_req != inject_seen) begin
            flash_mem_readdatavalid = 1'b1;
            inject_seen             = inject_req;
        end
    end

    // Output monitor: each new write strobe is scored against the queue.
    always @(posedge clk_clk) begin
        exp_t e;
        #1;
        if (write_s && !prev_ws) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", 32'(write_s), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sample", 32'(sample), 32'(e.smp));
                checkOutput("write_addr", 32'(flash_mem_address), 32'(e.addr));
            end
        end
        if (done) begin
            done_cnt++;
            checkOutput("done_addr", 32'(flash_mem_address), 32'd0);
            checkOutput("done_one_cycle", 32'(prev_done), 32'd0);
        end
        prev_ws   = write_s;
        prev_done = done;
    end

    task automatic doReset();
        run           = 1'b0;
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        sb.delete();
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        if (sb.size() != 0)
            checkOutput(name, 32'(sb.size()), 32'd0);
        repeat (12) @(posedge clk_clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        doReset();
        mode       = v.mode;
        data_sel   = 1'b1;
        const_word = v.word;
        for (int k = 0; k < v.n; k++)
            sb.push_back('{shape(v.s[k]), 23'd0});
        run = 1'b1;
        @(posedge clk_clk);
        #1;
        checkOutput("req_latency", 32'(flash_mem_read), 32'd1);
        run = 1'b0;
        waitDrain(300, "vec_timeout");
        checkOutput("vec_idle_read", 32'(flash_mem_read), 32'd0);
        checkOutput("vec_idle_addr", 32'(flash_mem_address), 32'd1);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] c_smp[10];
        logic [22:0] c_adr[10];

        vecs[0] = '{2'b00, 32'h0001FFFF, 2, '{16'hFFFF, 16'h0001, 16'h0, 16'h0}};
        vecs[1] = '{2'b01, 32'h0001FFFF, 4, '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001}};
        vecs[2] = '{2'b10, 32'h0001FFFF, 1, '{16'hFFFF, 16'h0, 16'h0, 16'h0}};
        vecs[3] = '{2'b11, 32'h0001FFFF, 2, '{16'hFFFF, 16'h0001, 16'h0, 16'h0}};
        vecs[4] = '{2'b00, 32'h80007FFF, 2, '{16'h7FFF, 16'h8000, 16'h0, 16'h0}};
        vecs[5] = '{2'b10, 32'h12345678, 1, '{16'h5678, 16'h0, 16'h0, 16'h0}};

        c_smp = '{16'h0000, 16'h0000, 16'h2712, 16'h0000, 16'h4E24,
                  16'h0000, 16'h7536, 16'h0000, 16'h0000, 16'h0000};
        c_adr = '{23'd0, 23'd0, 23'd1, 23'd1, 23'd2, 23'd2, 23'd3, 23'd3, 23'd0, 23'd0};

        reset_reset_n         = 1'b0;
        run                   = 1'b0;
        mode                  = 2'b00;
        flash_mem_waitrequest = 1'b0;

        // Reset values
        doReset();
        checkOutput("rst_read", 32'(flash_mem_read), 32'd0);
        checkOutput("rst_addr", 32'(flash_mem_address), 32'd0);
        checkOutput("rst_burst", 32'(flash_mem_burstcount), 32'd1);
        checkOutput("rst_write_s", 32'(write_s), 32'd0);
        checkOutput("rst_sample", 32'(sample), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);

        // Table-driven single-word playback in every mode
        foreach (vecs[i])
            applyStimulus(vecs[i]);

        // Normal mode across the wrap, run dropped mid-word on the second lap
        doReset();
        mode     = 2'b00;
        data_sel = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++)
            sb.push_back('{shape(c_smp[k]), c_adr[k]});
        run = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk_clk);
            #1;
            if (sb.size() <= 1)
                run = 1'b0;
            n++;
        end
        if (sb.size() != 0)
            checkOutput("wrap_timeout", 32'(sb.size()), 32'd0);
        run = 1'b0;
        repeat (12) @(posedge clk_clk);
        #1;
        checkOutput("wrap_done_count", 32'(done_cnt), 32'd1);
        checkOutput("stop_addr", 32'(flash_mem_address), 32'd1);
        checkOutput("stop_read", 32'(flash_mem_read), 32'd0);

        // Waitrequest stall: read and address must hold for all six request cycles
        doReset();
        mode                  = 2'b00;
        data_sel              = 1'b1;
        const_word            = 32'h0001FFFF;
        flash_mem_waitrequest = 1'b1;
        sb.push_back('{shape(16'hFFFF), 23'd0});
        sb.push_back('{shape(16'h0001), 23'd0});
        run = 1'b1;
        @(posedge clk_clk);
        #1;
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput("stall_read", 32'(flash_mem_read), 32'd1);
            checkOutput("stall_addr", 32'(flash_mem_address), 32'd0);
            if (k == 5)
                flash_mem_waitrequest = 1'b0;
            @(posedge clk_clk);
            #1;
        end
        checkOutput("stall_release", 32'(flash_mem_read), 32'd0);
        waitDrain(300, "stall_timeout");
        checkOutput("stall_idle_addr", 32'(flash_mem_address), 32'd1);

        // Reset mid-write, then a stray readdatavalid after release
        doReset();
        mode     = 2'b00;
        data_sel = 1'b0;
        for (int k = 0; k < 6; k++)
            sb.push_back('{shape(c_smp[k]), c_adr[k]});
        run = 1'b1;
        n = 0;
        while (!(write_s && flash_mem_address == 23'd2) && n < 500) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        checkOutput("pre_reset_write_s", 32'(write_s), 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("async_write_s", 32'(write_s), 32'd0);
        checkOutput("async_addr", 32'(flash_mem_address), 32'd0);
        checkOutput("async_sample", 32'(sample), 32'd0);
        checkOutput("async_read", 32'(flash_mem_read), 32'd0);
        run = 1'b0;
        sb.delete();
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        inject_req++;
        repeat (10) @(posedge clk_clk);
        #1;
        checkOutput("stale_read", 32'(flash_mem_read), 32'd0);
        checkOutput("stale_addr", 32'(flash_mem_address), 32'd0);
        checkOutput("stale_sample", 32'(sample), 32'd0);
        checkOutput("stale_write_s", 32'(write_s), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
